// File: rtl/alu_element_vector_if.sv
// Operand/result bundle for one lane of the vector element ALU.
interface alu_element_vector_if #(
  parameter int ELEMENT_SIZE = 16
) ();
  logic [ELEMENT_SIZE-1:0] elementA;
  logic [ELEMENT_SIZE-1:0] elementB;
  logic [2:0]              sel;
  logic                    in_valid;
  logic [ELEMENT_SIZE-1:0] result;
  logic [ELEMENT_SIZE-1:0] result_q;
  logic                    out_valid;
  logic                    flag_zero;
  logic                    flag_neg;
  logic                    flag_carry;
  logic                    flag_ovf;

  modport master (
    output elementA, elementB, sel, in_valid,
    input  result, result_q, out_valid, flag_zero, flag_neg, flag_carry, flag_ovf
  );

  modport slave (
    input  elementA, elementB, sel, in_valid,
    output result, result_q, out_valid, flag_zero, flag_neg, flag_carry, flag_ovf
  );
endinterface

// File: rtl/alu_element_vector.sv
// Single-lane element ALU: combinational result plus registered result/flags.
// Define ALU_ELEM_MUL_EN to build the multiplier for sel 010; otherwise sel 010 yields 0.
module alu_element_vector #(
  parameter int ELEMENT_SIZE = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_element_vector_if.slave bus
);
  localparam int N = ELEMENT_SIZE;
  localparam logic [N-1:0] N_AMT = N'(N);

  logic [N-1:0]        a;
  logic [N-1:0]        b;
  logic [N:0]          add_full;
  logic [N:0]          sub_full;
  logic [N-1:0]        mul_res;
  logic signed [N-1:0] sra_res;
  logic                shift_big;
  logic [N-1:0]        alu_res;
  logic                carry_c;
  logic                ovf_c;

  logic [N-1:0] result_d,     result_q;
  logic         out_valid_d,  out_valid_q;
  logic         flag_zero_d,  flag_zero_q;
  logic         flag_neg_d,   flag_neg_q;
  logic         flag_carry_d, flag_carry_q;
  logic         flag_ovf_d,   flag_ovf_q;

  assign a = bus.elementA;
  assign b = bus.elementB;

  always_comb begin
    add_full  = {1'b0, a} + {1'b0, b};
    // Zero-extended subtract: the extra MSB is the unsigned borrow.
    sub_full  = {1'b0, a} - {1'b0, b};
`ifdef ALU_ELEM_MUL_EN
    mul_res   = a * b;
`else
    mul_res   = '0;
`endif
    // Full-width B is the shift amount; anything >= N saturates.
    shift_big = (b >= N_AMT);
    sra_res   = $signed(a) >>> b;

    alu_res = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    unique case (bus.sel)
      3'b000: begin
        alu_res = add_full[N-1:0];
        carry_c = add_full[N];
        ovf_c   = (a[N-1] == b[N-1]) && (add_full[N-1] != a[N-1]);
      end
      3'b001: begin
        alu_res = sub_full[N-1:0];
        carry_c = sub_full[N];
        ovf_c   = (a[N-1] != b[N-1]) && (sub_full[N-1] != a[N-1]);
      end
      3'b010:  alu_res = mul_res;
      3'b011:  alu_res = shift_big ? {N{a[N-1]}} : sra_res;
      3'b100:  alu_res = shift_big ? '0 : (a >> b);
      3'b101:  alu_res = shift_big ? '0 : (a << b);
      3'b110:  alu_res = a & b;
      default: alu_res = a ^ b;
    endcase
  end

  always_comb begin
    out_valid_d  = bus.in_valid;
    result_d     = result_q;
    flag_zero_d  = flag_zero_q;
    flag_neg_d   = flag_neg_q;
    flag_carry_d = flag_carry_q;
    flag_ovf_d   = flag_ovf_q;
    if (bus.in_valid) begin
      result_d     = alu_res;
      flag_zero_d  = (alu_res == '0);
      flag_neg_d   = alu_res[N-1];
      flag_carry_d = carry_c;
      flag_ovf_d   = ovf_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q     <= '0;
      out_valid_q  <= 1'b0;
      flag_zero_q  <= 1'b1;
      flag_neg_q   <= 1'b0;
      flag_carry_q <= 1'b0;
      flag_ovf_q   <= 1'b0;
    end else begin
      result_q     <= result_d;
      out_valid_q  <= out_valid_d;
      flag_zero_q  <= flag_zero_d;
      flag_neg_q   <= flag_neg_d;
      flag_carry_q <= flag_carry_d;
      flag_ovf_q   <= flag_ovf_d;
    end
  end

  assign bus.result     = alu_res;
  assign bus.result_q   = result_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.flag_zero  = flag_zero_q;
  assign bus.flag_neg   = flag_neg_q;
  assign bus.flag_carry = flag_carry_q;
  assign bus.flag_ovf   = flag_ovf_q;
endmodule

// File: tb/tb_alu_element_vector.sv
// Self-checking bench for alu_element_vector: directed plan vectors, register/reset behaviour, random ops.
module tb_alu_element_vector;
  localparam int    N    = 16;
  localparam longint MOD  = longint'(1) << N;
  localparam longint HALF = MOD / 2;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  longint exp_q;
  bit     exp_z, exp_n, exp_c, exp_o, exp_v;

  alu_element_vector_if #(.ELEMENT_SIZE(N)) bus ();

  alu_element_vector #(.ELEMENT_SIZE(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference built from plain integer arithmetic.
  function automatic void ref_alu(input longint a, input longint b, input int s,
                                  output longint r, output bit c, output bit o);
    longint sa, sb, t, p;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    p  = (b < N) ? (longint'(1) << b) : 0;
    r = 0; c = 0; o = 0;
    case (s)
      0: begin t = a + b; r = t % MOD; c = (t >= MOD); t = sa + sb; o = (t >= HALF) || (t < -HALF); end
      1: begin r = (a - b + MOD) % MOD; c = (a < b); t = sa - sb; o = (t >= HALF) || (t < -HALF); end
`ifdef ALU_ELEM_MUL_EN
      2: r = (a * b) % MOD;
`else
      2: r = 0;
`endif
      3: begin
        if (b >= N) r = (sa < 0) ? MOD - 1 : 0;
        else begin
          t = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
          r = (t + MOD) % MOD;
        end
      end
      4: r = (b >= N) ? 0 : a / p;
      5: r = (b >= N) ? 0 : (a * p) % MOD;
      6: r = a & b;
      default: r = a ^ b;
    endcase
  endfunction

  task automatic chk_regs(input string pfx);
    chk({pfx, " result_q"},   bus.result_q,   exp_q[31:0]);
    chk({pfx, " out_valid"},  bus.out_valid,  exp_v);
    chk({pfx, " flag_zero"},  bus.flag_zero,  exp_z);
    chk({pfx, " flag_neg"},   bus.flag_neg,   exp_n);
    chk({pfx, " flag_carry"}, bus.flag_carry, exp_c);
    chk({pfx, " flag_ovf"},   bus.flag_ovf,   exp_o);
  endtask

  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] s, input bit v);
    longint r;
    bit c, o;
    @(negedge clk);
    bus.elementA = a;
    bus.elementB = b;
    bus.sel      = s;
    bus.in_valid = v;
    ref_alu(longint'(a), longint'(b), int'(s), r, c, o);
    #1;
    chk("result", bus.result, r[31:0]);
    @(posedge clk);
    #1;
    if (v) begin
      exp_q = r; exp_z = (r == 0); exp_n = (r >= HALF); exp_c = c; exp_o = o;
    end
    exp_v = v;
    chk_regs("reg");
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic [2:0] s; logic [15:0] lit; } vec_t;
  vec_t plan[$];

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0;
    bus.elementA = '0; bus.elementB = '0; bus.sel = '0; bus.in_valid = 1'b0;
    exp_q = 0; exp_z = 1; exp_n = 0; exp_c = 0; exp_o = 0; exp_v = 0;

    plan.push_back('{16'd8,     16'd5,     3'b000, 16'd13});
    plan.push_back('{16'd10,    16'd3,     3'b001, 16'd7});
    plan.push_back('{16'h7FFF,  16'd1,     3'b000, 16'h8000});
    plan.push_back('{16'd3,     16'd5,     3'b001, 16'hFFFE});
`ifdef ALU_ELEM_MUL_EN
    plan.push_back('{16'd5,     16'd6,     3'b010, 16'd30});
`else
    plan.push_back('{16'd5,     16'd6,     3'b010, 16'd0});
`endif
    plan.push_back('{16'h0100,  16'h0100,  3'b010, 16'h0000});
    plan.push_back('{16'd32,    16'd2,     3'b011, 16'd8});
    plan.push_back('{16'd32,    16'd2,     3'b100, 16'd8});
    plan.push_back('{16'd4,     16'd2,     3'b101, 16'd16});
    plan.push_back('{16'h8000,  16'd4,     3'b011, 16'hF800});
    plan.push_back('{16'h8000,  16'd4,     3'b100, 16'h0800});
    plan.push_back('{16'h8000,  16'd16,    3'b011, 16'hFFFF});
    plan.push_back('{16'h8000,  16'd16,    3'b100, 16'h0000});
    plan.push_back('{16'hFFFF,  16'd16,    3'b101, 16'h0000});
    plan.push_back('{16'hFFFF,  16'h0110,  3'b100, 16'h0000});
    plan.push_back('{16'h8000,  16'h0110,  3'b011, 16'hFFFF});
    plan.push_back('{16'd15,    16'd10,    3'b110, 16'd10});
    plan.push_back('{16'd15,    16'd10,    3'b111, 16'd5});

    #12;
    chk_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (plan[i]) begin
      step(plan[i].a, plan[i].b, plan[i].s, 1'b1);
      chk($sformatf("plan%0d literal", i), bus.result, plan[i].lit);
    end

    step(16'd8, 16'd5, 3'b000, 1'b1);
    chk("capture 13", bus.result_q, 16'd13);
    chk("capture valid", bus.out_valid, 1'b1);
    step(16'd1, 16'd1, 3'b111, 1'b0);
    chk("hold 13", bus.result_q, 16'd13);
    chk("hold valid", bus.out_valid, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    exp_q = 0; exp_z = 1; exp_n = 0; exp_c = 0; exp_o = 0; exp_v = 0;
    chk_regs("async rst");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_regs("post rst");

    // Capture straight after reset release, then reset mid-stream.
    step(16'h7FFF, 16'h0001, 3'b000, 1'b1);
    step(16'h0003, 16'h0005, 3'b001, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q = 0; exp_z = 1; exp_n = 0; exp_c = 0; exp_o = 0; exp_v = 0;
    chk_regs("midstream rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] ra, rb;
      logic [2:0]   rs;
      bit           rv;
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) ra = (ra[0]) ? 16'h8000 : 16'h7FFF;
      rs = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 3) != 0);
      step(ra, rb, rs, rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
